// File: rtl/ikbd_pointer_arbiter.sv
// rtl/ikbd_pointer_arbiter.sv - registered mouse/joystick-0 arbiter for the 6301 pointer input path
//
// Ports:
//   clk           system clock (2 MHz ikbd clock)
//   res           asynchronous, active-high reset
//   mouse_atari   {right btn, left btn, YB, YA, XB, XA} from the ps2 block
//   joystick0     {fire, R, L, D, U}, active-high
//   force_sel     00/11 auto, 01 force mouse, 10 force joystick
//   mouse_joy     arbitrated pointer value to the port logic (registered)
//   mouse_active  1 = mouse owns (or is about to own) the path
//   switching     1 while a hand-over guard interval is in progress
module ikbd_pointer_arbiter #(
    parameter int HOLDOFF = 200000,
    parameter int GUARD   = 64,
    parameter int CW      = 18
) (
    input  logic       clk,
    input  logic       res,
    input  logic [5:0] mouse_atari,
    input  logic [4:0] joystick0,
    input  logic [1:0] force_sel,
    output logic [5:0] mouse_joy,
    output logic       mouse_active,
    output logic       switching
);

    localparam logic [1:0] ST_MOUSE   = 2'd0;
    localparam logic [1:0] ST_G2JOY   = 2'd1;
    localparam logic [1:0] ST_JOY     = 2'd2;
    localparam logic [1:0] ST_G2MOUSE = 2'd3;

    localparam logic [CW-1:0] HOLD_C     = CW'(HOLDOFF);
    localparam logic [CW-1:0] GUARD_LAST = CW'(GUARD - 1);

    logic [1:0]    state;
    logic [5:0]    last_mouse;
    logic [4:0]    last_joy;
    logic [CW-1:0] idle_cnt;
    logic [CW-1:0] guard_cnt;
    logic          pend;

    logic       in_mouse;
    logic       in_joy;
    logic       owner_state;
    logic       m_act;
    logic       j_act;
    logic       own_act;
    logic       oth_act;
    logic       force_away;
    logic       force_hold;
    logic       auto_sw;
    logic       go_guard;
    logic       guard_done;
    logic [5:0] joy_ext;
    logic [5:0] owner_val;

    assign in_mouse    = (state == ST_MOUSE);
    assign in_joy      = (state == ST_JOY);
    assign owner_state = in_mouse | in_joy;

    assign m_act   = (mouse_atari != last_mouse);
    assign j_act   = (joystick0 != last_joy);
    assign own_act = in_mouse ? m_act : j_act;
    assign oth_act = in_mouse ? j_act : m_act;

    // Forcing away from the current owner bypasses hold-off and pend;
    // forcing toward it pins the path and suppresses auto switches.
    assign force_away = (in_mouse && force_sel == 2'b10) || (in_joy && force_sel == 2'b01);
    assign force_hold = (in_mouse && force_sel == 2'b01) || (in_joy && force_sel == 2'b10);

    assign auto_sw    = pend && (idle_cnt == HOLD_C) && !force_hold;
    assign go_guard   = owner_state && (force_away || auto_sw);
    assign guard_done = !owner_state && (guard_cnt == GUARD_LAST);

    assign joy_ext   = {1'b0, joystick0};
    assign owner_val = in_mouse ? mouse_atari : joy_ext;

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state        <= ST_MOUSE;
            mouse_joy    <= 6'b0;
            mouse_active <= 1'b1;
            switching    <= 1'b0;
            last_mouse   <= 6'b0;
            last_joy     <= 5'b0;
            idle_cnt     <= '0;
            guard_cnt    <= '0;
            pend         <= 1'b0;
        end else begin
            last_mouse <= mouse_atari;
            last_joy   <= joystick0;

            if (owner_state) begin
                if (go_guard) begin
                    state        <= in_mouse ? ST_G2JOY : ST_G2MOUSE;
                    guard_cnt    <= '0;
                    pend         <= 1'b0;
                    switching    <= 1'b1;
                    // mouse_active already names the destination owner.
                    mouse_active <= in_joy;
                    // Release buttons, freeze direction/quadrature bits.
                    mouse_joy    <= {2'b00, mouse_joy[3:0]};
                end else begin
                    mouse_joy <= owner_val;

                    if (own_act)
                        idle_cnt <= '0;
                    else if (idle_cnt != HOLD_C)
                        idle_cnt <= idle_cnt + 1'b1;

                    // Owner activity beats a simultaneous non-owner request.
                    if (force_hold || own_act)
                        pend <= 1'b0;
                    else if (oth_act)
                        pend <= 1'b1;
                end
            end else begin
                // Guard: output stays frozen, activity is only tracked in last_*.
                if (guard_done) begin
                    state     <= (state == ST_G2JOY) ? ST_JOY : ST_MOUSE;
                    idle_cnt  <= '0;
                    pend      <= 1'b0;
                    switching <= 1'b0;
                    mouse_joy <= (state == ST_G2JOY) ? joy_ext : mouse_atari;
                end else if (guard_cnt != {CW{1'b1}}) begin
                    guard_cnt <= guard_cnt + 1'b1;
                end
            end
        end
    end

endmodule
